// File: rtl/voting_tally_seq.sv
// Sequential ballot tally: counts votes per candidate, then scans the
// counters one per cycle to pick the winner (lowest index wins a tie).
module voting_tally_seq #(
  parameter int NUM_CAND  = 3,
  parameter int MAX_VOTES = 8,
  localparam int CAND_W = $clog2(NUM_CAND),
  localparam int CNT_W  = $clog2(MAX_VOTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              close,
  input  logic              vote_valid,
  input  logic [CAND_W-1:0] vote_data,
  output logic              vote_ready,
  output logic              winner_valid,
  output logic [CAND_W-1:0] winner,
  output logic [CNT_W-1:0]  winner_count,
  output logic              tie,
  output logic [CNT_W-1:0]  invalid_count
);

  localparam logic [CAND_W:0]   NC   = NUM_CAND[CAND_W:0];
  localparam logic [CAND_W-1:0] LAST = CAND_W'(NUM_CAND - 1);
  localparam logic [CNT_W-1:0]  MAXV = CNT_W'(MAX_VOTES);

  typedef enum logic [1:0] {IDLE, COLLECT, SCAN, DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_CAND-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]  total, inv;
  logic [CAND_W-1:0] idx, best;
  logic [CNT_W-1:0]  best_cnt;
  logic              tie_r;

  logic clr, acc, in_range, scan_go;

  // start clears everywhere except SCAN; a ballot colliding with start is dropped
  assign clr      = start && (state != SCAN);
  assign acc      = vote_valid && vote_ready && !start;
  assign in_range = {1'b0, vote_data} < NC;
  assign scan_go  = (state == COLLECT) && close && !start;

  assign vote_ready    = (state == COLLECT) && (total < MAXV);
  assign winner_valid  = (state == DONE);
  assign winner        = winner_valid ? best     : '0;
  assign winner_count  = winner_valid ? best_cnt : '0;
  assign tie           = winner_valid ? tie_r    : 1'b0;
  assign invalid_count = inv;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode; close in IDLE and start/close in SCAN are ignored
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (start) state_nxt = COLLECT;
               else if (close) state_nxt = SCAN;
      SCAN:    if (idx == LAST) state_nxt = DONE;
      DONE:    if (start) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  // ballot counters; total caps at MAX_VOTES via vote_ready so nothing wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      total <= '0;
      inv   <= '0;
    end else if (clr) begin
      cnt   <= '0;
      total <= '0;
      inv   <= '0;
    end else if (acc) begin
      total <= total + 1'b1;
      if (!in_range) inv <= inv + 1'b1;
      for (int i = 0; i < NUM_CAND; i++)
        if (in_range && vote_data == CAND_W'(i)) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  // winner scan: one candidate per cycle, strict > moves best, == flags tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      best     <= '0;
      best_cnt <= '0;
      tie_r    <= 1'b0;
    end else if (scan_go || clr) begin
      idx      <= '0;
      best     <= '0;
      best_cnt <= '0;
      tie_r    <= 1'b0;
    end else if (state == SCAN) begin
      idx <= idx + 1'b1;
      if (cnt[idx] > best_cnt) begin
        best     <= idx;
        best_cnt <= cnt[idx];
        tie_r    <= 1'b0;
      end else if (cnt[idx] == best_cnt) begin
        tie_r    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_voting_tally_seq.sv
// Directed bench for voting_tally_seq (NUM_CAND=3, MAX_VOTES=8).
module tb_voting_tally_seq;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0, close = 0, vote_valid = 0;
  logic [1:0] vote_data = 0;
  logic       vote_ready, winner_valid, tie;
  logic [1:0] winner;
  logic [3:0] winner_count, invalid_count;

  int errs = 0;
  int checks = 0;

  voting_tally_seq #(.NUM_CAND(3), .MAX_VOTES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .close(close),
    .vote_valid(vote_valid), .vote_data(vote_data), .vote_ready(vote_ready),
    .winner_valid(winner_valid), .winner(winner), .winner_count(winner_count),
    .tie(tie), .invalid_count(invalid_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic vote(input logic [1:0] d);
    vote_valid = 1; vote_data = d;
    cyc();
    vote_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  // close (optionally with a ballot in the same cycle), then check result timing
  task automatic fin(input string tag, input logic with_vote, input logic [1:0] d,
                     input logic poke_start, input int w, input int wc,
                     input int t, input int iv);
    close = 1; vote_valid = with_vote; vote_data = d;
    cyc();
    close = 0; vote_valid = 0; start = poke_start;
    cyc();
    start = 0;
    chk({tag, ":winner_gated"}, winner, 0);
    cyc();
    chk({tag, ":wv_early"}, winner_valid, 0);
    cyc();
    chk({tag, ":wv"}, winner_valid, 1);
    chk({tag, ":winner"}, winner, w);
    chk({tag, ":count"}, winner_count, wc);
    chk({tag, ":tie"}, tie, t);
    chk({tag, ":inv"}, invalid_count, iv);
    cyc(); cyc();
    chk({tag, ":hold"}, winner, w);
  endtask

  initial begin
    #12;
    chk("rst:wv", winner_valid, 0);
    chk("rst:ready", vote_ready, 0);
    chk("rst:inv", invalid_count, 0);
    rst_n = 1;
    cyc();
    // IDLE: ballots refused, close ignored
    vote_valid = 1; vote_data = 1; close = 1;
    cyc();
    chk("idle:ready", vote_ready, 0);
    chk("idle:wv", winner_valid, 0);
    vote_valid = 0; close = 0;

    // scenario 1: plain majority
    pulse_start();
    chk("s1:ready", vote_ready, 1);
    vote(1); vote(1); vote(2); vote(0); vote(1); vote(2); vote(0); vote(1);
    chk("s1:full", vote_ready, 0);
    fin("s1", 0, 0, 0, 1, 4, 0, 0);

    // scenario 2: tie, lowest index wins, last ballot coincides with close
    pulse_start();
    chk("s2:wv_drop", winner_valid, 0);
    chk("s2:ready", vote_ready, 1);
    vote(2); vote(0); vote(2);
    fin("s2", 1, 0, 0, 0, 2, 1, 0);

    // scenario 3: invalid ballots, start during SCAN ignored
    pulse_start();
    vote(3); vote(3);
    chk("s3:inv_live", invalid_count, 2);
    vote(1);
    fin("s3", 0, 0, 1, 1, 1, 0, 2);

    // scenario 4: capacity limit with vote_valid held high
    pulse_start();
    vote_valid = 1;
    vote_data = 3; cyc(); cyc(); cyc();
    vote_data = 1; cyc(); cyc(); cyc(); cyc();
    chk("s4:ready7", vote_ready, 1);
    cyc();
    chk("s4:ready8", vote_ready, 0);
    cyc();
    vote_valid = 0;
    fin("s4", 0, 0, 0, 1, 5, 0, 3);

    // scenario 5: start mid-collection clears and discards the coincident ballot
    pulse_start();
    vote(0); vote(0); vote(3);
    start = 1; vote_valid = 1; vote_data = 1;
    cyc();
    start = 0; vote_valid = 0;
    chk("s5:inv_clr", invalid_count, 0);
    vote(2);
    fin("s5", 0, 0, 0, 2, 1, 0, 0);

    // scenario 6: reset during SCAN
    pulse_start();
    vote(1); vote(3);
    close = 1; cyc(); close = 0;
    cyc();
    rst_n = 0; #1;
    chk("s6:inv", invalid_count, 0);
    chk("s6:wv", winner_valid, 0);
    chk("s6:ready", vote_ready, 0);
    cyc();
    rst_n = 1;
    vote_valid = 1; vote_data = 0;
    cyc(); cyc();
    chk("s6:idle_ready", vote_ready, 0);
    chk("s6:idle_wv", winner_valid, 0);
    vote_valid = 0;
    pulse_start();
    chk("s6:ready_after", vote_ready, 1);

    // scenario 7: empty election, then start drops winner_valid
    fin("s7", 0, 0, 0, 0, 0, 1, 0);
    pulse_start();
    chk("s7:wv_drop", winner_valid, 0);
    chk("s7:tie_gated", tie, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
